bus_datapath_seq: RTL and testbench

Parametrised successor to the single-bus mini-CPU datapath, with a built-in microstep sequencer so the datapath runs register-to-register programs on its own.
- Contents: GPR file, PC, IR, MAR, MDR, Y, Z(hi/lo), HI/LO, one encoded internal bus, internal ALU.
- Sequencer: fetch/execute state machine that generates every Rin/Rout/Yin/Zin strobe itself and fetches instruction words over a req/ack memory port.
- Position: sits between the phase-3 control-unit work and the memory/IO blocks; used as a self-running core for system-level tests.

---
 rtl/bus_datapath_pkg.sv | 28 ++
 rtl/bus_datapath_seq_alu.sv | 37 +++
 rtl/bus_datapath_seq.sv | 171 +++++++++++++++++
 tb/tb_bus_datapath_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_datapath_pkg.sv
// bus_datapath_pkg: opcodes, sequencer states, bus source selects and ALU op type.
// MUL_HILO_EN makes MUL/MFHI/MFLO legal opcodes.
package bus_datapath_pkg;
    typedef logic [4:0] alu_op_t;
    localparam alu_op_t OP_ADD  = 5'b00011;
    localparam alu_op_t OP_SUB  = 5'b00100;
    localparam alu_op_t OP_AND  = 5'b00101;
    localparam alu_op_t OP_OR   = 5'b00110;
    localparam alu_op_t OP_SHR  = 5'b00111;
    localparam alu_op_t OP_SHL  = 5'b01001;
    localparam alu_op_t OP_MUL  = 5'b01111;
    localparam alu_op_t OP_NEG  = 5'b10001;
    localparam alu_op_t OP_NOT  = 5'b10010;
    localparam alu_op_t OP_MFHI = 5'b11000;
    localparam alu_op_t OP_MFLO = 5'b11001;
    localparam alu_op_t OP_HALT = 5'b11011;
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE} state_t;
    typedef enum logic [2:0] {SRC_GPR, SRC_PC, SRC_MDR, SRC_HI, SRC_LO, SRC_ZLO, SRC_ZHI, SRC_NONE} bus_sel_t;
`ifdef MUL_HILO_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    function automatic logic op_legal(input alu_op_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_NEG, OP_NOT, OP_HALT}
            || (MUL_EN && op inside {OP_MUL, OP_MFHI, OP_MFLO});
    endfunction
endpackage

// File: rtl/bus_datapath_seq_alu.sv
// dp_alu: combinational ALU producing the 2W-wide value loaded into Z.
// MUL_HILO_EN adds the signed W x W multiplier.
module dp_alu
    import bus_datapath_pkg::*;
#(
    parameter int W = 32
) (
    input  alu_op_t          op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   z
);
    logic [W-1:0] lo;
    logic         big;
    assign big = b >= W'(W);
    always_comb begin
        case (op)
            OP_ADD:  lo = a + b;
            OP_SUB:  lo = a - b;
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_SHR:  lo = big ? '0 : a >> b;
            OP_SHL:  lo = big ? '0 : a << b;
            OP_NEG:  lo = '0 - b;
            OP_NOT:  lo = ~b;
            default: lo = '0;
        endcase
    end
`ifdef MUL_HILO_EN
    logic [2*W-1:0] prod;
    // sign-extend both operands so the low 2W bits of the product are the signed result
    assign prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    assign z = op == OP_MUL ? prod : {{W{1'b0}}, lo};
`else
    assign z = {{W{1'b0}}, lo};
`endif
endmodule

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: single-bus datapath with a built-in fetch/execute microstep sequencer.
// MUL_HILO_EN enables MUL, MFHI, MFLO and the HI/LO registers.
module bus_datapath_seq
    import bus_datapath_pkg::*;
#(
    parameter int            W        = 32,
    parameter int            NUM_REGS = 16,
    localparam int           RAW      = $clog2(NUM_REGS),
    parameter logic [W-1:0]  PC_RESET = '0
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   mem_addr,
    output logic           mem_rd,
    input  logic [W-1:0]   mem_rdata,
    input  logic           mem_ack,
    input  logic [RAW-1:0] dbg_addr,
    output logic [W-1:0]   dbg_data,
    output logic [W-1:0]   pc_out
);
    localparam int IRW = 5 + 3*RAW;
    state_t           state_q, state_d;
    logic [W-1:0]     pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
    logic [IRW-1:0]   ir_q, ir_d;
    logic [2*W-1:0]   z_q, z_d, alu_z;
    logic [W-1:0]     gpr_q [NUM_REGS];
    logic [W-1:0]     gpr_d [NUM_REGS];
    logic             err_q, err_d, gpr_we, y_in;
    bus_sel_t         sel;
    logic [RAW-1:0]   rsel, ra, rb, rc;
    logic [W-1:0]     bus, hi_bus, lo_bus;
    alu_op_t          op;

    assign op = ir_q[IRW-1 -: 5];
    assign ra = ir_q[IRW-6 -: RAW];
    assign rb = ir_q[IRW-6-RAW -: RAW];
    assign rc = ir_q[RAW-1:0];

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        sel     = SRC_NONE;
        rsel    = rb;
        gpr_we  = 1'b0;
        y_in    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = T0;
                err_d   = 1'b0;
            end
            T0: begin
                sel     = SRC_PC;
                state_d = T1;
            end
            T1: state_d = mem_ack ? T2 : T1;
            T2: begin
                sel     = SRC_MDR;
                state_d = T3;
            end
            T3: if (op == OP_HALT) state_d = DONE;
                else if (!op_legal(op)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (op inside {OP_MFHI, OP_MFLO}) begin
                    sel     = op == OP_MFHI ? SRC_HI : SRC_LO;
                    gpr_we  = 1'b1;
                    state_d = T0;
                end else begin
                    sel     = SRC_GPR;
                    y_in    = 1'b1;
                    state_d = T4;
                end
            T4: begin
                sel     = SRC_GPR;
                rsel    = op inside {OP_NEG, OP_NOT} ? rb : rc;
                state_d = T5;
            end
            T5: begin
                sel     = SRC_ZLO;
                gpr_we  = 1'b1;
                state_d = op == OP_MUL ? T6 : T0;
            end
            T6: state_d = T0;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (sel)
            SRC_GPR: bus = gpr_q[rsel];
            SRC_PC:  bus = pc_q;
            SRC_MDR: bus = mdr_q;
            SRC_HI:  bus = hi_bus;
            SRC_LO:  bus = lo_bus;
            SRC_ZLO: bus = z_q[W-1:0];
            SRC_ZHI: bus = z_q[2*W-1:W];
            default: bus = '0;
        endcase
    end

    dp_alu #(.W(W)) u_alu (.op(op), .a(y_q), .b(bus), .z(alu_z));

    always_comb begin
        pc_d  = state_q == T0 ? pc_q + W'(1) : pc_q;
        mar_d = state_q == T0 ? bus : mar_q;
        mdr_d = state_q == T1 && mem_ack ? mem_rdata : mdr_q;
        ir_d  = state_q == T2 ? bus[W-1 -: IRW] : ir_q;
        y_d   = y_in ? bus : y_q;
        z_d   = state_q == T4 ? alu_z : z_q;
        gpr_d = gpr_q;
        if (gpr_we) gpr_d[ra] = bus;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            y_q     <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
            gpr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            y_q     <= y_d;
            z_q     <= z_d;
            err_q   <= err_d;
            gpr_q   <= gpr_d;
        end
    end

`ifdef MUL_HILO_EN
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
    always_comb begin
        hi_d = state_q == T6 ? z_q[2*W-1:W] : hi_q;
        lo_d = state_q == T6 ? z_q[W-1:0] : lo_q;
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign hi_bus = hi_q;
    assign lo_bus = lo_q;
`else
    assign hi_bus = '0;
    assign lo_bus = '0;
`endif

    assign busy     = state_q != IDLE && state_q != DONE;
    assign done     = state_q == DONE;
    assign err      = err_q;
    assign mem_addr = mar_q;
    assign mem_rd   = state_q == T1;
    assign dbg_data = gpr_q[dbg_addr];
    assign pc_out   = pc_q;
endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb_bus_datapath_seq: directed programs with hand-computed register, PC and status results.
// Constants are built from zeroed GPRs with NOT/NEG/ADD/SHL; MUL_HILO_EN adds a MUL/MFHI/MFLO program.
module tb_bus_datapath_seq;
    import bus_datapath_pkg::*;
    logic        clk, clr, start, busy, done, err, mem_rd, mem_ack, spur, err_at_start;
    logic [31:0] mem_addr, mem_rdata, dbg_data, pc_out;
    logic [3:0]  dbg_addr;
    logic [31:0] mem [256];
    int checks = 0, errors = 0, done_cnt = 0;
    int ack_dly, wcnt, rd_run, last_run, a, d0;

    bus_datapath_seq dut (
        .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc_out(pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (done) done_cnt++;

    // memory responder: acks after ack_dly stalled cycles, drives junk (illegal opcode) otherwise
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '1;
        wcnt = 0;
        rd_run = 0;
        last_run = 0;
        forever begin
            @(negedge clk);
            rd_run = mem_rd ? rd_run + 1 : 0;
            if (mem_rd && wcnt >= ack_dly) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr[7:0]];
                last_run = rd_run;
                wcnt = 0;
            end else begin
                mem_ack = spur;
                mem_rdata = '1;
                wcnt = mem_rd ? wcnt + 1 : 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [4:0] op, input int ra, input int rb, input int rc);
        return {op, ra[3:0], rb[3:0], rc[3:0], 15'b0};
    endfunction

    task automatic put(input logic [31:0] w);
        mem[a] = w;
        a++;
    endtask

    task automatic gpr(input int r, input logic [31:0] exp);
        dbg_addr = r[3:0];
        #1;
        check($sformatf("r%0d", r), dbg_data, exp);
    endtask

    task automatic run(input int poke);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err_at_start = err;
        check("busy_rise", {31'b0, busy}, 32'd1);
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
            start = n == poke;
        end
        start = 1'b0;
        check("finish", {31'b0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b0;
        start = 1'b0;
        spur = 1'b0;
        ack_dly = 0;
        dbg_addr = '0;
        a = 0;
        for (int i = 0; i < 256; i++) mem[i] = '1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        for (int r = 0; r < 16; r++) gpr(r, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        // build constants, then ADD r7 = 5 + 7
        put(ins(OP_NOT, 1, 0, 0));
        put(ins(OP_NEG, 2, 1, 0));
        put(ins(OP_ADD, 3, 2, 2));
        put(ins(OP_ADD, 4, 3, 3));
        put(ins(OP_ADD, 5, 4, 2));
        put(ins(OP_ADD, 6, 5, 3));
        put(ins(OP_ADD, 7, 5, 6));
        put(ins(OP_HALT, 0, 0, 0));
        d0 = done_cnt;
        run(0);
        check("a_done_once", done_cnt - d0, 32'd1);
        check("a_pc", pc_out, a);
        check("a_err", {31'b0, err}, 32'd0);
        gpr(1, 32'hFFFF_FFFF);
        gpr(2, 32'd1);
        gpr(4, 32'd4);
        gpr(5, 32'd5);
        gpr(6, 32'd7);
        gpr(7, 32'd12);
        // every fetch stalled 4 cycles
        ack_dly = 4;
        put(ins(OP_SUB, 8, 6, 5));
        put(ins(OP_ADD, 9, 8, 6));
        put(ins(OP_HALT, 0, 0, 0));
        d0 = done_cnt;
        run(0);
        check("b_done_once", done_cnt - d0, 32'd1);
        check("b_rd_held", last_run, 32'd5);
        check("b_pc", pc_out, a);
        gpr(8, 32'd2);
        gpr(9, 32'd9);
        ack_dly = 0;
        // aliasing, shift bounds, NEG/NOT edge values, logic ops
        put(ins(OP_SUB, 9, 9, 9));
        put(ins(OP_SHL, 10, 2, 5));
        put(ins(OP_ADD, 10, 10, 2));
        put(ins(OP_SHL, 7, 2, 10));
        put(ins(OP_SUB, 14, 10, 3));
        put(ins(OP_SHL, 13, 2, 14));
        put(ins(OP_NEG, 13, 13, 0));
        put(ins(OP_NEG, 11, 2, 0));
        put(ins(OP_SHR, 12, 1, 5));
        put(ins(OP_AND, 15, 12, 6));
        put(ins(OP_OR, 0, 13, 2));
        put(ins(OP_SHR, 8, 13, 14));
        put(ins(OP_HALT, 0, 0, 0));
        run(0);
        check("c_pc", pc_out, a);
        gpr(9, 32'd0);
        gpr(10, 32'd33);
        gpr(7, 32'd0);
        gpr(14, 32'd31);
        gpr(13, 32'h8000_0000);
        gpr(11, 32'hFFFF_FFFF);
        gpr(12, 32'h07FF_FFFF);
        gpr(15, 32'd7);
        gpr(0, 32'h8000_0001);
        gpr(8, 32'd1);
        // illegal opcode: err set, no write, no done
        put(ins(5'b11111, 3, 1, 1));
        d0 = done_cnt;
        run(0);
        check("ill_err", {31'b0, err}, 32'd1);
        check("ill_no_done", done_cnt - d0, 32'd0);
        check("ill_pc", pc_out, a);
        gpr(3, 32'd2);
`ifdef MUL_HILO_EN
        put(ins(OP_MUL, 4, 11, 12));
        put(ins(OP_MFHI, 5, 0, 0));
        put(ins(OP_MFLO, 6, 0, 0));
        put(ins(OP_HALT, 0, 0, 0));
        run(0);
        check("mul_err_cleared", {31'b0, err_at_start}, 32'd0);
        check("mul_err", {31'b0, err}, 32'd0);
        check("mul_pc", pc_out, a);
        gpr(4, 32'hF800_0001);
        gpr(5, 32'hFFFF_FFFF);
        gpr(6, 32'hF800_0001);
`else
        put(ins(OP_MUL, 4, 11, 12));
        run(0);
        check("mul_err_cleared", {31'b0, err_at_start}, 32'd0);
        check("mul_illegal", {31'b0, err}, 32'd1);
        check("mul_pc", pc_out, a);
        gpr(4, 32'd4);
`endif
        // start while busy is ignored
        put(ins(OP_ADD, 3, 3, 3));
        put(ins(OP_HALT, 0, 0, 0));
        d0 = done_cnt;
        run(3);
        check("poke_done_once", done_cnt - d0, 32'd1);
        check("poke_pc", pc_out, a);
        check("poke_err", {31'b0, err}, 32'd0);
        gpr(3, 32'd4);
        // ack with no read outstanding
        spur = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_busy", {31'b0, busy}, 32'd0);
        check("spur_pc", pc_out, a);
        spur = 1'b0;
        @(negedge clk);
        // reset while in T4
        put(ins(OP_ADD, 9, 6, 6));
        put(ins(OP_HALT, 0, 0, 0));
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        clr = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_pc", pc_out, 32'd0);
        check("mid_rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_done", done_cnt - d0, 32'd0);
        check("post_rst_pc", pc_out, 32'd0);
        gpr(9, 32'd0);
        gpr(6, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
